// File: rtl/uart_byte_receiver_if.sv
// Receive-side signal bundle between the UART pin and the byte consumer.
interface uart_byte_receiver_if;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_framing_err;
    logic       rx_busy;

    // Receiver side: samples the line, produces bytes and status.
    modport master (
        input  uart_rx,
        output rx_data,
        output rx_valid,
        output rx_framing_err,
        output rx_busy
    );

    // Consumer side: drives the line, observes bytes and status.
    modport slave (
        output uart_rx,
        input  rx_data,
        input  rx_valid,
        input  rx_framing_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, one-cycle valid / framing-error pulses.
module uart_byte_receiver #(
    parameter logic [23:0] BAUD_RATE  = 24'd4000000,
    parameter logic [27:0] CLOCK_FREQ = 28'd50000000
) (
    input logic                  clk,
    input logic                  reset,
    uart_byte_receiver_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = 32'(CLOCK_FREQ) / 32'(BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    // Fewer than 4 clocks per bit leaves no room to find the bit centre.
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("uart_byte_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_err_q, rx_err_d;
    logic             rx_busy_q, rx_busy_d;
    logic             rx_s;

    assign rx_s = sync2_q;

    // Next-state and output computation; every decision uses the synchronized line.
    always_comb begin
        state_d    = state_q;
        sync1_d    = bus.uart_rx;
        sync2_d    = sync1_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        // Busy trails the state by one cycle so it drops the cycle after a pulse.
        rx_busy_d  = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CNT_HALF_END) begin
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    // A line that is high again at mid start bit was a glitch.
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CNT_BIT_END) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CNT_BIT_END) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                // Hold here through a long low line so only one error pulse results.
                if (rx_s) begin
                    state_d   = ST_IDLE;
                    clk_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign bus.rx_data        = rx_data_q;
    assign bus.rx_valid       = rx_valid_q;
    assign bus.rx_framing_err = rx_err_q;
    assign bus.rx_busy        = rx_busy_q;
endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver at default rates (12 clocks per bit).
module tb_uart_byte_receiver;
    localparam int unsigned CPB = 12;

    logic clk = 1'b0;
    logic reset;

    uart_byte_receiver_if bus_if();

    uart_byte_receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
    } pulse_t;

    pulse_t      vq[$];
    int unsigned eq[$];
    logic        prev_busy     = 1'b0;
    int unsigned busy_fall_cyc = 0;
    bit          busy_seen     = 1'b0;
    bit          both_seen     = 1'b0;
    int unsigned start_cyc     = 0;
    logic [7:0]  exp_last      = 8'h00;

    int checks = 0;
    int passed = 0;

    // Record every output pulse away from the active edge.
    always @(negedge clk) begin
        if (bus_if.rx_valid === 1'b1) vq.push_back('{cyc, bus_if.rx_data});
        if (bus_if.rx_framing_err === 1'b1) eq.push_back(cyc);
        if (bus_if.rx_valid === 1'b1 && bus_if.rx_framing_err === 1'b1) both_seen = 1'b1;
        if (bus_if.rx_busy === 1'b1) busy_seen = 1'b1;
        if (prev_busy === 1'b1 && bus_if.rx_busy === 1'b0) busy_fall_cyc = cyc;
        prev_busy = bus_if.rx_busy;
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame, LSB first, followed by gap_bits idle-high bit times.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int unsigned gap_bits);
        bus_if.uart_rx = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus_if.uart_rx = data[i];
            tick(CPB);
        end
        bus_if.uart_rx = stop_ok;
        tick(CPB);
        bus_if.uart_rx = 1'b1;
        tick(gap_bits * CPB);
    endtask

    task automatic clear_log();
        vq.delete();
        eq.delete();
        busy_seen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.uart_rx = 1'b1;
        tick(5);
        checks++; if (bus_if.rx_data !== 8'h00) $display("FAIL reset_data: got %0h want 00", bus_if.rx_data); else passed++;
        checks++; if (bus_if.rx_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus_if.rx_valid); else passed++;
        checks++; if (bus_if.rx_framing_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", bus_if.rx_framing_err); else passed++;
        checks++; if (bus_if.rx_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus_if.rx_busy); else passed++;
        reset = 1'b0;
        clear_log();
        tick(500);
        checks++; if (vq.size() != 0) $display("FAIL idle_valid: got %0d pulses want 0", vq.size()); else passed++;
        checks++; if (eq.size() != 0 || busy_seen) $display("FAIL idle_quiet: got err=%0d busy=%0b want 0/0", eq.size(), busy_seen); else passed++;
    endtask

    task automatic test_single_byte();
        int unsigned lat;
        clear_log();
        send_frame(8'hA5, 1'b1, 2);
        exp_last = 8'hA5;
        checks++; if (vq.size() != 1) $display("FAIL single_count: got %0d want 1", vq.size()); else passed++;
        if (vq.size() >= 1) begin
            lat = vq[0].cyc - start_cyc;
            checks++; if (vq[0].data !== 8'hA5) $display("FAIL single_data: got %0h want a5", vq[0].data); else passed++;
            checks++; if (lat < 115 || lat > 119) $display("FAIL single_latency: got %0d want 115..119", lat); else passed++;
            checks++; if (busy_fall_cyc != vq[0].cyc + 1) $display("FAIL single_busy_fall: got cycle %0d want %0d", busy_fall_cyc, vq[0].cyc + 1); else passed++;
        end
        checks++; if (bus_if.rx_data !== 8'hA5) $display("FAIL single_hold: got %0h want a5", bus_if.rx_data); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h5A;
        clear_log();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, (i == 2) ? 2 : 0);
        exp_last = 8'h5A;
        checks++; if (vq.size() != 3) $display("FAIL b2b_count: got %0d want 3", vq.size()); else passed++;
        checks++; if (eq.size() != 0) $display("FAIL b2b_err: got %0d want 0", eq.size()); else passed++;
        for (int i = 0; i < 3 && i < vq.size(); i++) begin
            checks++; if (vq[i].data !== exp_b[i]) $display("FAIL b2b_data%0d: got %0h want %0h", i, vq[i].data, exp_b[i]); else passed++;
            if (i > 0) begin
                checks++;
                if (vq[i].cyc - vq[i-1].cyc < 118 || vq[i].cyc - vq[i-1].cyc > 122)
                    $display("FAIL b2b_spacing%0d: got %0d want 118..122", i, vq[i].cyc - vq[i-1].cyc);
                else passed++;
            end
        end
    endtask

    task automatic test_glitch();
        clear_log();
        bus_if.uart_rx = 1'b0;
        tick(3);
        bus_if.uart_rx = 1'b1;
        tick(30);
        checks++; if (!busy_seen) $display("FAIL glitch_busy_seen: got 0 want 1"); else passed++;
        checks++; if (bus_if.rx_busy !== 1'b0) $display("FAIL glitch_busy_end: got %0b want 0", bus_if.rx_busy); else passed++;
        checks++; if (vq.size() != 0 || eq.size() != 0) $display("FAIL glitch_pulses: got valid=%0d err=%0d want 0/0", vq.size(), eq.size()); else passed++;
        send_frame(8'h3C, 1'b1, 2);
        exp_last = 8'h3C;
        checks++; if (vq.size() != 1 || bus_if.rx_data !== 8'h3C) $display("FAIL glitch_next: got count=%0d data=%0h want 1/3c", vq.size(), bus_if.rx_data); else passed++;
    endtask

    task automatic test_framing_error();
        clear_log();
        send_frame(8'hC3, 1'b0, 0);
        bus_if.uart_rx = 1'b0;
        tick(60);
        bus_if.uart_rx = 1'b1;
        tick(2 * CPB);
        checks++; if (eq.size() != 1) $display("FAIL frame_err_count: got %0d want 1", eq.size()); else passed++;
        checks++; if (vq.size() != 0) $display("FAIL frame_no_valid: got %0d want 0", vq.size()); else passed++;
        checks++; if (bus_if.rx_data !== exp_last) $display("FAIL frame_hold: got %0h want %0h", bus_if.rx_data, exp_last); else passed++;
        send_frame(8'h81, 1'b1, 2);
        exp_last = 8'h81;
        checks++; if (vq.size() != 1 || bus_if.rx_data !== 8'h81) $display("FAIL frame_recover: got count=%0d data=%0h want 1/81", vq.size(), bus_if.rx_data); else passed++;
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        d = 8'hF0;
        clear_log();
        bus_if.uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus_if.uart_rx = d[i];
            tick(CPB);
        end
        reset = 1'b1;
        bus_if.uart_rx = 1'b1;
        tick(3);
        checks++; if (bus_if.rx_data !== 8'h00 || bus_if.rx_busy !== 1'b0) $display("FAIL abort_reset: got data=%0h busy=%0b want 00/0", bus_if.rx_data, bus_if.rx_busy); else passed++;
        reset = 1'b0;
        tick(2 * CPB);
        checks++; if (vq.size() != 0 || eq.size() != 0) $display("FAIL abort_pulses: got valid=%0d err=%0d want 0/0", vq.size(), eq.size()); else passed++;
        send_frame(8'h0F, 1'b1, 2);
        exp_last = 8'h0F;
        checks++; if (vq.size() != 1 || bus_if.rx_data !== 8'h0F) $display("FAIL abort_next: got count=%0d data=%0h want 1/0f", vq.size(), bus_if.rx_data); else passed++;
    endtask

    // Random frames: good bytes must appear once each, in order; bad stop bits give one error each.
    task automatic test_random_stream(input int unsigned n_frames, input bit allow_bad, input string tag);
        logic [7:0]  exp_q[$];
        int unsigned start_q[$];
        int unsigned exp_errs;
        logic [7:0]  d;
        bit          ok;
        int unsigned lat;
        clear_log();
        exp_errs = 0;
        for (int i = 0; i < int'(n_frames); i++) begin
            d  = 8'($urandom);
            ok = !allow_bad || ($urandom_range(0, 4) != 0);
            send_frame(d, ok, ok ? $urandom_range(0, 2) : $urandom_range(1, 3));
            if (ok) begin
                exp_q.push_back(d);
                start_q.push_back(start_cyc);
                exp_last = d;
            end else begin
                exp_errs++;
            end
        end
        tick(2 * CPB);
        checks++; if (vq.size() != exp_q.size()) $display("FAIL %s_count: got %0d want %0d", tag, vq.size(), exp_q.size()); else passed++;
        checks++; if (eq.size() != exp_errs) $display("FAIL %s_errs: got %0d want %0d", tag, eq.size(), exp_errs); else passed++;
        for (int i = 0; i < exp_q.size() && i < vq.size(); i++) begin
            lat = vq[i].cyc - start_q[i];
            checks++; if (vq[i].data !== exp_q[i]) $display("FAIL %s_data%0d: got %0h want %0h", tag, i, vq[i].data, exp_q[i]); else passed++;
            checks++; if (lat < 115 || lat > 119) $display("FAIL %s_latency%0d: got %0d want 115..119", tag, i, lat); else passed++;
        end
        checks++; if (bus_if.rx_data !== exp_last) $display("FAIL %s_last: got %0h want %0h", tag, bus_if.rx_data, exp_last); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        bus_if.uart_rx = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_abort();
        test_random_stream(32, 1'b0, "integration");
        test_random_stream(24, 1'b1, "mixed");
        checks++; if (both_seen) $display("FAIL exclusive_pulses: got valid&err together want never"); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
